z80_bus_arbiter: RTL and testbench

//   Shares the Z80 system bus between the CPU and up to NUM_REQ external bus masters (DMA, video fetch, ...).

---
 rtl/z80_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
// Z80 bus arbiter: requests the bus from the CPU via BUSREQ#, grants one
// external master round-robin once BUSACK# is seen, bounds each tenure and
// hands the bus back to the CPU for a guaranteed minimum gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | CPU owns bus, BUSREQ# high, waiting for any request
// REQ     | BUSREQ# low, waiting for BUSACK# low
// GRANT   | one master owns the bus, tenure counted
// DRAIN   | one turnaround cycle, no grant, BUSREQ# still low
// RELEASE | BUSREQ# high, waiting for BUSACK# high
// GAP     | CPU keeps the bus for MIN_GAP cycles
module z80_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64,
  parameter int MIN_GAP  = 4
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic [NUM_REQ-1:0]                            i_req,
  output logic [NUM_REQ-1:0]                            o_gnt,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_owner,
  output logic                                          o_busreq_n,
  input  logic                                          i_busack_n,
  output logic                                          o_timeout
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                busreq_n_q, busreq_n_d;
  logic                timeout_q, timeout_d;

  logic                win_ok;
  logic [OW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_gnt;
  logic [OW-1:0]       owner_inc;

  // Round-robin winner: first set request at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win_ok  = 1'b0;
    win_idx = '0;
    win_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (i_req[idx]) begin
        win_ok  = 1'b1;
        win_idx = OW'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      win_gnt[i] = win_ok && (win_idx == OW'(i));
    end
  end

  assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) state_d = REQ;
      end
      REQ: begin
        // A request withdrawn here cannot cancel BUSREQ#: the CPU has committed.
        if (!i_busack_n) begin
          if (win_ok) begin
            state_d = GRANT;
            gnt_d   = win_gnt;
            owner_d = win_idx;
            hold_d  = HW'(1);
          end else begin
            state_d = RELEASE;
          end
        end
      end
      GRANT: begin
        if (i_busack_n) begin
          // CPU let go of the bus underneath us: revoke at once, skip DRAIN.
          state_d = GAP;
          gap_d   = '0;
          ptr_d   = owner_inc;
        end else if (!i_req[owner_q]) begin
          state_d = DRAIN;
          ptr_d   = owner_inc;
        end else if ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD))) begin
          state_d   = DRAIN;
          ptr_d     = owner_inc;
          timeout_d = 1'b1;
        end else begin
          gnt_d = gnt_q;
          if (MAX_HOLD != 0) hold_d = hold_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (i_busack_n) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GW'(MIN_GAP - 1)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busreq_n_d = !((state_d == REQ) || (state_d == GRANT) || (state_d == DRAIN));
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
      busreq_n_q <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      busreq_n_q <= busreq_n_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_owner    = owner_q;
  assign o_busreq_n = busreq_n_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter with a small Z80 BUSREQ/BUSACK model
// and a queue of expected grant owners.
module tb_z80_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ACK_DLY = 3;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         owner;
  logic               busreq_n;
  logic               busack_n;
  logic               timeout;

  logic               z80_abort;
  int                 ack_cnt;

  int checks;
  int failures;
  int exp_q[$];

  z80_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_HOLD(64),
    .MIN_GAP (4)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_owner   (owner),
    .o_busreq_n(busreq_n),
    .i_busack_n(busack_n),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Z80 model: acknowledges BUSREQ# after ACK_DLY cycles, releases at once.
  initial begin
    busack_n = 1'b1;
    ack_cnt  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (z80_abort) begin
        busack_n = 1'b1;
      end else if (!busreq_n) begin
        if (busack_n) begin
          ack_cnt++;
          if (ack_cnt >= ACK_DLY) busack_n = 1'b0;
        end
      end else begin
        ack_cnt  = 0;
        busack_n = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag);
    int e;
    logic [NUM_REQ-1:0] oh;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(gnt), 32'(0));
    end else begin
      e  = exp_q.pop_front();
      oh = '0;
      oh[e] = 1'b1;
      check({tag, "_gnt"}, 32'(gnt), 32'(oh));
      check({tag, "_owner"}, 32'(owner), 32'(e));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input int budget, output int hi_cnt, output bit ok);
    hi_cnt = 0;
    ok     = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      if (busreq_n) hi_cnt++;
    end
  endtask

  task automatic wait_no_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (gnt == '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    int hi;
    int bad;
    int n;
    bit ok;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req       = '0;
    z80_abort = 1'b0;

    // Reset values
    step(2);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_busreq_n", 32'(busreq_n), 32'(1));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    rst = 1'b0;

    // Idle with no requests
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busreq_n || gnt != '0) bad++;
    end
    check("idle_100", 32'(bad), 32'(0));

    // Single request, exact latencies
    req = 4'b0001;
    exp_q.push_back(0);
    step(1);
    check("single_busreq_lat", 32'(busreq_n), 32'(0));
    check("single_nognt_early", 32'(gnt), 32'(0));
    step(2);
    check("single_nognt_at_ack", 32'(gnt), 32'(0));
    step(1);
    check_grant("single");
    req = 4'b0000;
    step(1);
    check("single_drain_gnt", 32'(gnt), 32'(0));
    check("single_drain_busreq", 32'(busreq_n), 32'(0));
    step(1);
    check("single_release_busreq", 32'(busreq_n), 32'(1));
    step(10);

    // All requesting: round-robin order with gaps
    do_reset();
    req = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_no_gnt(100, ok);
        check("rr_release", 32'(ok), 32'(1));
      end
      wait_gnt(200, hi, ok);
      check("rr_wait", 32'(ok), 32'(1));
      check_grant("rr");
      if (k > 0) check("rr_min_gap", 32'(hi >= 4), 32'(1));
    end
    req = 4'b0000;
    step(20);

    // Tenure limit on a held request
    do_reset();
    req = 4'b0100;
    exp_q.push_back(2);
    wait_gnt(50, hi, ok);
    check("hold_wait", 32'(ok), 32'(1));
    check_grant("hold");
    n = 0;
    while (gnt[2] && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("hold_len", 32'(n), 32'(64));
    check("hold_timeout_pulse", 32'(timeout), 32'(1));
    check("hold_gnt_off", 32'(gnt), 32'(0));
    step(1);
    check("hold_timeout_end", 32'(timeout), 32'(0));
    exp_q.push_back(2);
    wait_gnt(200, hi, ok);
    check("hold_regrant_wait", 32'(ok), 32'(1));
    check_grant("hold_regrant");
    step(20);
    req = 4'b0000;
    step(20);

    // Request withdrawn before acknowledge
    do_reset();
    req = 4'b0010;
    step(1);
    check("drop_busreq", 32'(busreq_n), 32'(0));
    req = 4'b0000;
    step(1);
    check("drop_busreq_held1", 32'(busreq_n), 32'(0));
    step(1);
    check("drop_busreq_held2", 32'(busreq_n), 32'(0));
    step(1);
    check("drop_release", 32'(busreq_n), 32'(1));
    check("drop_nognt", 32'(gnt), 32'(0));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busreq_n || gnt != '0) bad++;
    end
    check("drop_quiet", 32'(bad), 32'(0));

    // CPU releases BUSACK# during a grant
    do_reset();
    req = 4'b0001;
    exp_q.push_back(0);
    wait_gnt(50, hi, ok);
    check("abort_wait", 32'(ok), 32'(1));
    check_grant("abort");
    step(5);
    z80_abort = 1'b1;
    step(1);
    check("abort_gnt", 32'(gnt), 32'(0));
    check("abort_busreq", 32'(busreq_n), 32'(1));
    check("abort_timeout", 32'(timeout), 32'(0));
    z80_abort = 1'b0;
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (timeout || !busreq_n) bad++;
    end
    check("abort_gap", 32'(bad), 32'(0));

    // Reset asserted mid-grant
    req = 4'b1000;
    exp_q.push_back(3);
    wait_gnt(50, hi, ok);
    check("rstgnt_wait", 32'(ok), 32'(1));
    check_grant("rstgnt");
    step(3);
    rst = 1'b1;
    #1;
    check("rstgnt_gnt", 32'(gnt), 32'(0));
    check("rstgnt_busreq", 32'(busreq_n), 32'(1));
    req = 4'b0000;
    step(2);
    rst = 1'b0;
    step(2);

    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
